// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: grant encodings and
// the read-response tags that route data back to the issuing port.
package sdram_arb_pkg;

   localparam logic [1:0] GNT_IDLE = 2'd0;
   localparam logic [1:0] GNT_A    = 2'd1;
   localparam logic [1:0] GNT_B    = 2'd2;

   typedef enum logic [1:0] {
      GRANT_IDLE = GNT_IDLE,
      GRANT_A    = GNT_A,
      GRANT_B    = GNT_B
   } grant_e;

   localparam logic TAG_A = 1'b0;
   localparam logic TAG_B = 1'b1;

endpackage

// File: rtl/sdram_rd_tag_fifo.sv
// In-order queue of 1-bit read tags; the head tells which port owns the
// next read response coming back from the SDRAM controller.
module sdram_rd_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             push_tag,
   input  logic             pop,
   output logic             head_tag,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign head_tag = empty ? TAG_A : mem[rd_ptr];

   // Tag storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM slave between the VGA line fetcher (port A,
// priority reads) and the frame loader (port B, writes and verify reads).
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 16,
   parameter int MAX_PENDING = 8,
   parameter int MAX_RUN     = 16
)(
   input  logic                         iCLK,
   input  logic                         iRST_N,
   input  logic                         iA_RD,
   input  logic [ADDR_W-1:0]            iA_ADDR,
   output logic                         oA_WAIT,
   output logic [DATA_W-1:0]            oA_RDDATA,
   output logic                         oA_RDVALID,
   input  logic                         iB_RD,
   input  logic                         iB_WR,
   input  logic [ADDR_W-1:0]            iB_ADDR,
   input  logic [DATA_W-1:0]            iB_WDATA,
   output logic                         oB_WAIT,
   output logic [DATA_W-1:0]            oB_RDDATA,
   output logic                         oB_RDVALID,
   output logic [ADDR_W-1:0]            oS_ADDR,
   output logic                         oS_READ_N,
   output logic                         oS_WRITE_N,
   output logic [DATA_W-1:0]            oS_WDATA,
   input  logic                         iS_WAIT,
   input  logic                         iS_RDVALID,
   input  logic [DATA_W-1:0]            iS_RDDATA,
   output logic [1:0]                   oGRANT,
   output logic [$clog2(MAX_PENDING):0] oPENDING,
   output logic                         oERR
);

   localparam int PEND_W = $clog2(MAX_PENDING) + 1;
   localparam int RUN_W  = $clog2(MAX_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

   grant_e           gnt;
   grant_e           gnt_nxt;
   logic [RUN_W-1:0] run_cnt;
   logic             err;

   logic b_req;
   logic gnt_req;
   logic gnt_rd;
   logic blocked;
   logic accepted;
   logic stalled;

   logic fifo_full;
   logic fifo_empty;
   logic head_tag;
   logic tag_push;
   logic tag_pop;
   logic push_tag;

   assign b_req = iB_RD | iB_WR;

   // What the granted port is asking for; a B write beats a simultaneous B read.
   always_comb begin
      gnt_req = 1'b0;
      gnt_rd  = 1'b0;
      case (gnt)
         GRANT_A: begin
            gnt_req = iA_RD;
            gnt_rd  = 1'b1;
         end
         GRANT_B: begin
            gnt_req = b_req;
            gnt_rd  = ~iB_WR;
         end
         default: begin
            gnt_req = 1'b0;
            gnt_rd  = 1'b0;
         end
      endcase
   end

   assign blocked  = gnt_req & gnt_rd & fifo_full;
   assign accepted = gnt_req & ~blocked & ~iS_WAIT;
   assign stalled  = gnt_req & ~blocked & iS_WAIT;

   // A blocked read is hidden from the slave so the tag queue cannot overflow.
   always_comb begin
      oS_ADDR    = '0;
      oS_WDATA   = '0;
      oS_READ_N  = 1'b1;
      oS_WRITE_N = 1'b1;
      oA_WAIT    = 1'b1;
      oB_WAIT    = 1'b1;
      case (gnt)
         GRANT_A: begin
            oS_ADDR   = iA_ADDR;
            oS_READ_N = ~(iA_RD & ~blocked);
            oA_WAIT   = iS_WAIT | blocked;
         end
         GRANT_B: begin
            oS_ADDR    = iB_ADDR;
            oS_WDATA   = iB_WDATA;
            oS_WRITE_N = ~iB_WR;
            oS_READ_N  = ~(iB_RD & ~iB_WR & ~blocked);
            oB_WAIT    = iS_WAIT | blocked;
         end
         default: begin
            oS_ADDR = '0;
         end
      endcase
   end

   // A stalled command must stay on the bus, so the grant is frozen then.
   always_comb begin
      gnt_nxt = gnt;
      if (!stalled) begin
         case (gnt)
            GRANT_A: begin
               if (accepted) begin
                  gnt_nxt = (b_req && run_cnt == RUN_LAST) ? GRANT_B : GRANT_A;
               end else begin
                  gnt_nxt = b_req ? GRANT_B : GRANT_IDLE;
               end
            end
            GRANT_IDLE, GRANT_B: begin
               if (iA_RD) begin
                  gnt_nxt = GRANT_A;
               end else if (b_req) begin
                  gnt_nxt = GRANT_B;
               end else begin
                  gnt_nxt = GRANT_IDLE;
               end
            end
            default: gnt_nxt = GRANT_IDLE;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         gnt     <= GRANT_IDLE;
         run_cnt <= '0;
         err     <= 1'b0;
      end else begin
         gnt <= gnt_nxt;
         if (!b_req || gnt_nxt != GRANT_A) begin
            run_cnt <= '0;
         end else if (gnt == GRANT_A && accepted) begin
            run_cnt <= run_cnt + 1'b1;
         end
         if ((iB_RD & iB_WR) | (iS_RDVALID & fifo_empty)) begin
            err <= 1'b1;
         end
      end
   end

   assign tag_push = accepted & gnt_rd;
   assign push_tag = (gnt == GRANT_B) ? TAG_B : TAG_A;
   assign tag_pop  = iS_RDVALID & ~fifo_empty;

   sdram_rd_tag_fifo #(
      .DEPTH (MAX_PENDING),
      .CNT_W (PEND_W)
   ) u_tag_fifo (
      .clk      (iCLK),
      .rst_n    (iRST_N),
      .push     (tag_push),
      .push_tag (push_tag),
      .pop      (tag_pop),
      .head_tag (head_tag),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (oPENDING)
   );

   assign oA_RDVALID = tag_pop & (head_tag == TAG_A);
   assign oB_RDVALID = tag_pop & (head_tag == TAG_B);
   assign oA_RDDATA  = iS_RDDATA;
   assign oB_RDDATA  = iS_RDDATA;
   assign oGRANT     = gnt;
   assign oERR       = err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter: Avalon masters and a latency
// slave around the DUT, compared each cycle against a behavioural model.
module tb_sdram_port_arbiter;

   localparam int ADDR_W      = 25;
   localparam int DATA_W      = 16;
   localparam int MAX_PENDING = 8;
   localparam int MAX_RUN     = 16;

   logic              iCLK = 1'b0;
   logic              iRST_N = 1'b0;
   logic              iA_RD = 1'b0;
   logic [ADDR_W-1:0] iA_ADDR = '0;
   logic              oA_WAIT;
   logic [DATA_W-1:0] oA_RDDATA;
   logic              oA_RDVALID;
   logic              iB_RD = 1'b0;
   logic              iB_WR = 1'b0;
   logic [ADDR_W-1:0] iB_ADDR = '0;
   logic [DATA_W-1:0] iB_WDATA = '0;
   logic              oB_WAIT;
   logic [DATA_W-1:0] oB_RDDATA;
   logic              oB_RDVALID;
   logic [ADDR_W-1:0] oS_ADDR;
   logic              oS_READ_N;
   logic              oS_WRITE_N;
   logic [DATA_W-1:0] oS_WDATA;
   logic              iS_WAIT = 1'b0;
   logic              iS_RDVALID = 1'b0;
   logic [DATA_W-1:0] iS_RDDATA = '0;
   logic [1:0]        oGRANT;
   logic [3:0]        oPENDING;
   logic              oERR;

   sdram_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MAX_PENDING (MAX_PENDING),
      .MAX_RUN     (MAX_RUN)
   ) dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iA_RD      (iA_RD),
      .iA_ADDR    (iA_ADDR),
      .oA_WAIT    (oA_WAIT),
      .oA_RDDATA  (oA_RDDATA),
      .oA_RDVALID (oA_RDVALID),
      .iB_RD      (iB_RD),
      .iB_WR      (iB_WR),
      .iB_ADDR    (iB_ADDR),
      .iB_WDATA   (iB_WDATA),
      .oB_WAIT    (oB_WAIT),
      .oB_RDDATA  (oB_RDDATA),
      .oB_RDVALID (oB_RDVALID),
      .oS_ADDR    (oS_ADDR),
      .oS_READ_N  (oS_READ_N),
      .oS_WRITE_N (oS_WRITE_N),
      .oS_WDATA   (oS_WDATA),
      .iS_WAIT    (iS_WAIT),
      .iS_RDVALID (iS_RDVALID),
      .iS_RDDATA  (iS_RDDATA),
      .oGRANT     (oGRANT),
      .oPENDING   (oPENDING),
      .oERR       (oERR)
   );

   always #5 iCLK = ~iCLK;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state: grant owner, run length, tag order, sticky error.
   int                mGnt = 0;
   int                mRun = 0;
   bit                mErr = 1'b0;
   bit                mTags[$];
   logic [DATA_W-1:0] expA[$];
   logic [DATA_W-1:0] expB[$];

   // Traffic knobs and slave response pipeline.
   int pA = 0, pB = 0, pWait = 0, latMin = 2, latMax = 5;
   bit respEn = 1'b1, bWriteOnly = 1'b0, starveMode = 1'b0, forceBoth = 1'b0;
   bit aHold = 1'b0, bHold = 1'b0;
   int cyc = 0, lastReady = 0;
   int respReady[$];
   logic [DATA_W-1:0] respData[$];
   int aRun = 0, runsSeen = 0, blkSeen = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ {7'h00, a[24:16]} ^ 16'hC3A5;
   endfunction

   task automatic applyStimulus();
      if (!aHold) begin
         iA_RD   = ($urandom_range(99) < pA);
         iA_ADDR = ADDR_W'($urandom);
      end
      if (!bHold) begin
         if ($urandom_range(99) < pB) begin
            iB_WR = bWriteOnly ? 1'b1 : 1'($urandom_range(1));
            iB_RD = ~iB_WR;
         end else begin
            iB_WR = 1'b0;
            iB_RD = 1'b0;
         end
         iB_ADDR  = ADDR_W'($urandom);
         iB_WDATA = DATA_W'($urandom);
         if (forceBoth) begin
            iB_RD = 1'b1;
            iB_WR = 1'b1;
         end
      end
      iS_WAIT = ($urandom_range(99) < pWait);
      if (respEn && respReady.size() > 0 && respReady[0] <= cyc) begin
         iS_RDVALID = 1'b1;
         iS_RDDATA  = respData.pop_front();
         void'(respReady.pop_front());
      end else begin
         iS_RDVALID = 1'b0;
         iS_RDDATA  = DATA_W'($urandom);
      end
   endtask

   // One cycle of model evaluation: compare outputs, then advance model state.
   task automatic modelStep();
      bit bReq, req, rd, blk, acc, stl, popValid, tag, aAcc, bWrAcc;
      int ngnt, lat, r;
      logic [ADDR_W-1:0] ad;
      bReq = iB_RD || iB_WR;
      req = 1'b0; rd = 1'b0; ad = '0;
      if (mGnt == 1) begin req = iA_RD; rd = 1'b1; ad = iA_ADDR; end
      if (mGnt == 2) begin req = bReq; rd = !iB_WR; ad = iB_ADDR; end
      blk = req && rd && (mTags.size() == MAX_PENDING);
      acc = req && !blk && !iS_WAIT;
      stl = req && !blk && iS_WAIT;
      if (blk) blkSeen++;

      checkOutput("grant", 32'(oGRANT), 32'(mGnt));
      checkOutput("a_wait", 32'(oA_WAIT), (mGnt == 1) ? 32'(iS_WAIT || blk) : 32'd1);
      checkOutput("b_wait", 32'(oB_WAIT), (mGnt == 2) ? 32'(iS_WAIT || blk) : 32'd1);
      checkOutput("read_n", 32'(oS_READ_N), 32'(!(req && rd && !blk)));
      checkOutput("write_n", 32'(oS_WRITE_N), 32'(!(mGnt == 2 && iB_WR)));
      if (mGnt == 0) begin
         checkOutput("idle_addr", 32'(oS_ADDR), 32'd0);
         checkOutput("idle_wdata", 32'(oS_WDATA), 32'd0);
      end else if (req) begin
         checkOutput("cmd_addr", 32'(oS_ADDR), 32'(ad));
      end
      if (mGnt == 2 && iB_WR) checkOutput("wdata", 32'(oS_WDATA), 32'(iB_WDATA));
      checkOutput("pending", 32'(oPENDING), 32'(mTags.size()));
      checkOutput("err", 32'(oERR), 32'(mErr));

      popValid = iS_RDVALID && (mTags.size() > 0);
      tag = popValid ? mTags[0] : 1'b0;
      checkOutput("a_rdvalid", 32'(oA_RDVALID), 32'(popValid && !tag));
      checkOutput("b_rdvalid", 32'(oB_RDVALID), 32'(popValid && tag));
      if (oA_RDVALID) begin
         checkOutput("a_sb_nonempty", 32'(expA.size() > 0), 32'd1);
         if (expA.size() > 0) checkOutput("a_rddata", 32'(oA_RDDATA), 32'(expA.pop_front()));
      end
      if (oB_RDVALID) begin
         checkOutput("b_sb_nonempty", 32'(expB.size() > 0), 32'd1);
         if (expB.size() > 0) checkOutput("b_rddata", 32'(oB_RDDATA), 32'(expB.pop_front()));
      end

      // Slave side: answer reads the bus actually presented, in order.
      if (!oS_READ_N && !iS_WAIT) begin
         lat = $urandom_range(latMax, latMin);
         r = cyc + lat;
         if (r <= lastReady) r = lastReady + 1;
         lastReady = r;
         respReady.push_back(r);
         respData.push_back(memWord(oS_ADDR));
      end

      // Run-length check from bus observation only.
      aAcc   = (oGRANT == 2'd1) && !oS_READ_N && !iS_WAIT;
      bWrAcc = (oGRANT == 2'd2) && !oS_WRITE_N && !iS_WAIT;
      if (!bReq) aRun = 0;
      else if (aAcc) aRun++;
      if (bWrAcc) begin
         if (starveMode) begin
            runsSeen++;
            checkOutput("run_len", 32'(aRun), 32'(MAX_RUN));
         end
         aRun = 0;
      end

      if ((iB_RD && iB_WR) || (iS_RDVALID && mTags.size() == 0)) mErr = 1'b1;
      if (popValid) void'(mTags.pop_front());
      if (acc && rd) begin
         mTags.push_back(mGnt == 2);
         if (mGnt == 1) expA.push_back(memWord(iA_ADDR));
         else expB.push_back(memWord(iB_ADDR));
      end

      if (stl) ngnt = mGnt;
      else if (mGnt == 1) begin
         if (acc) ngnt = (bReq && mRun == MAX_RUN - 1) ? 2 : 1;
         else ngnt = bReq ? 2 : 0;
      end else ngnt = iA_RD ? 1 : (bReq ? 2 : 0);
      if (!bReq || ngnt != 1) mRun = 0;
      else if (mGnt == 1 && acc) mRun++;

      aHold = iA_RD && !(acc && mGnt == 1);
      bHold = bReq && !(acc && mGnt == 2);
      mGnt = ngnt;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge iCLK);
         applyStimulus();
         #1;
         modelStep();
         cyc++;
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_grant", 32'(oGRANT), 32'd0);
      checkOutput("rst_a_wait", 32'(oA_WAIT), 32'd1);
      checkOutput("rst_b_wait", 32'(oB_WAIT), 32'd1);
      checkOutput("rst_read_n", 32'(oS_READ_N), 32'd1);
      checkOutput("rst_write_n", 32'(oS_WRITE_N), 32'd1);
      checkOutput("rst_addr", 32'(oS_ADDR), 32'd0);
      checkOutput("rst_wdata", 32'(oS_WDATA), 32'd0);
      checkOutput("rst_a_rdvalid", 32'(oA_RDVALID), 32'd0);
      checkOutput("rst_b_rdvalid", 32'(oB_RDVALID), 32'd0);
      checkOutput("rst_pending", 32'(oPENDING), 32'd0);
      checkOutput("rst_err", 32'(oERR), 32'd0);
   endtask

   // Reset with requests and a response asserted, which must all be ignored.
   task automatic doReset();
      @(negedge iCLK);
      iRST_N = 1'b0;
      iA_RD = 1'b1; iB_WR = 1'b1; iB_RD = 1'b0; iS_RDVALID = 1'b1; iS_WAIT = 1'b0;
      #1;
      checkResetState();
      @(negedge iCLK);
      iA_RD = 1'b0; iB_WR = 1'b0; iB_RD = 1'b0; iS_RDVALID = 1'b0;
      iRST_N = 1'b1;
      mGnt = 0; mRun = 0; mErr = 1'b0;
      mTags.delete(); expA.delete(); expB.delete();
      respReady.delete(); respData.delete();
      lastReady = cyc; aHold = 1'b0; bHold = 1'b0; aRun = 0;
   endtask

   task automatic drain();
      bit done;
      int quiet;
      pA = 0; pB = 0; pWait = 0; respEn = 1'b1; starveMode = 1'b0; bWriteOnly = 1'b0;
      done = 1'b0; quiet = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         runCycles(1);
         if (!aHold && !bHold && respReady.size() == 0 && mTags.size() == 0) quiet++;
         else quiet = 0;
         done = (quiet >= 3);
      end
      checkOutput("drain_done", 32'(done), 32'd1);
      checkOutput("sb_empty", 32'(expA.size() + expB.size()), 32'd0);
   endtask

   initial begin
      doReset();

      pA = 60; pB = 40; pWait = 25; latMin = 2; latMax = 6;
      runCycles(1500);
      drain();

      // Responses withheld so the tag queue fills and A/B reads block.
      pA = 80; pB = 50; pWait = 10; respEn = 1'b0;
      runCycles(60);
      respEn = 1'b1;
      runCycles(200);
      drain();
      checkOutput("blocked_seen", 32'(blkSeen > 0), 32'd1);

      // A saturates the bus while B keeps a write waiting.
      pA = 100; pB = 100; bWriteOnly = 1'b1; pWait = 0; latMin = 3; latMax = 3; starveMode = 1'b1;
      runCycles(400);
      drain();
      checkOutput("runs_seen", 32'(runsSeen > 0), 32'd1);

      pA = 50; pB = 60; pWait = 60; latMin = 1; latMax = 8;
      runCycles(500);
      drain();

      respReady.push_back(cyc);
      respData.push_back(16'hDEAD);
      runCycles(3);
      checkOutput("spurious_err", 32'(oERR), 32'd1);

      doReset();
      forceBoth = 1'b1;
      runCycles(1);
      forceBoth = 1'b0;
      runCycles(4);
      checkOutput("both_err", 32'(oERR), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master arbiter sharing the single Avalon-MM SDRAM controller slave (16-bit, 25-bit word address) between the VGA line fetcher (port A, read-only, high priority) and the frame loader (port B, write plus read-back verify). It replaces the static write-done address/command mux in the top level, so loading and display can overlap. Read responses are routed back to the issuing port through an in-order tag queue.

## Interface
- ADDR_W, 25, word address width
- DATA_W, 16, data width
- MAX_PENDING, 8, max outstanding reads (power of two, 2..16)
- MAX_RUN, 16, consecutive port-A commands before a waiting port B gets one slot
- iCLK  in  1  SDRAM controller clock; sole clock
- iRST_N  in  1  asynchronous, active-low reset
- iA_RD  in  1  port A read request; iA_ADDR  in  ADDR_W
- oA_WAIT  out  1; oA_RDDATA  out  DATA_W; oA_RDVALID  out  1
- iB_RD, iB_WR  in  1 each; iB_ADDR  in  ADDR_W; iB_WDATA  in  DATA_W
- oB_WAIT  out  1; oB_RDDATA  out  DATA_W; oB_RDVALID  out  1
- oS_ADDR  out  ADDR_W; oS_READ_N, oS_WRITE_N  out  1; oS_WDATA  out  DATA_W (to controller)
- iS_WAIT, iS_RDVALID  in  1; iS_RDDATA  in  DATA_W (from controller)
- oGRANT  out  2  0 idle, 1 A, 2 B
- oPENDING  out  $clog2(MAX_PENDING)+1  outstanding reads
- oERR  out  1  sticky protocol-error flag

## Operation
- Grant register: IDLE/A/B. Slave command combinationally driven from granted port; IDLE drives READ_N=WRITE_N=1, ADDR/WDATA=0.
- Non-granted port: WAIT=1. Granted port: WAIT = iS_WAIT | blocked.
- blocked: granted command is a read and oPENDING==MAX_PENDING; read not presented to slave (READ_N=1). Writes never blocked.
- accepted: granted port requests, not blocked, iS_WAIT=0.
- stalled: granted port requests, not blocked, iS_WAIT=1. Grant never changes while stalled (Avalon hold rule).
- Next grant, when not stalled (blocked or idle port counts as not stalled):
  - IDLE: A if iA_RD, else B if iB_RD|iB_WR, else IDLE.
  - A accepted: B if B requests and run_cnt==MAX_RUN-1, else A.
  - A not requesting/blocked: B if B requests, else IDLE.
  - B accepted or not requesting/blocked: A if iA_RD, else B if B requests, else IDLE.
- run_cnt: +1 per A accept while B requests; cleared when B not requesting or grant leaves A.
- Accepted read: push tag (0=A, 1=B) into tag queue, pending+1.
- iS_RDVALID: pop tag, pending-1; assert that port's RDVALID; iS_RDDATA broadcast to both RDDATA.
- Push and pop same cycle: pending unchanged.
- iS_RDVALID with empty queue: data dropped, oERR set.
- iB_RD and iB_WR both high: write wins, oERR set.
- oERR clears only on reset.

## Timing
- Reset: grant IDLE, oA_WAIT=oB_WAIT=1, READ_N=WRITE_N=1, oS_ADDR/oS_WDATA=0, RDVALIDs 0, oPENDING=0, oERR=0, run_cnt 0, queue empty.
- Request from IDLE: grant next edge; command reaches slave 1 cycle after request; WAIT=1 on first cycle.
- Back-to-back commands of granted port: zero overhead, one per cycle when iS_WAIT=0.
- Grant switch costs one cycle only when the granted port goes idle.
- Read response routing: combinational, same cycle as iS_RDVALID.
- Reset mid-operation: all state cleared immediately; late responses from pre-reset reads hit empty queue and set oERR (benches tolerate).

## Structure
- Package sdram_arb_pkg: GNT_IDLE/GNT_A/GNT_B localparams, TAG_A/TAG_B.
- Sub-module sdram_rd_tag_fifo: 1-bit-wide, MAX_PENDING-deep synchronous FIFO with count, simultaneous push/pop, async active-low reset.
- Top holds grant FSM, run counter, command mux, error flag.

## Test plan
- Reset, no traffic -> oGRANT=0, both WAIT=1, READ_N=WRITE_N=1, oPENDING=0.
- A reads 0x100..0x103 back-to-back, iS_WAIT=0, 3-cycle read latency -> 4 commands on consecutive cycles, oA_RDVALID x4 in order, oB_RDVALID never.
- A continuous reads, B write 0x1ABCD=0x5A5A pending, MAX_RUN=16 -> exactly 16 A accepts, then the B write, then A resumes.
- iS_WAIT high 5 cycles on A read while B requests -> oGRANT stays 1, oS_ADDR stable, B waits.
- Interleaved A read, B read, A read -> RDVALID pulses A, B, A; oPENDING peaks 3, returns 0.
- 8 A reads accepted, no responses -> 9th blocked (READ_N=1, oA_WAIT=1), B write still granted and accepted; one response unblocks A next cycle.
